wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage: the MEM/WB pipeline register plus result selection and load extraction. It is the write-side driver of the register file's write port (we3/a3/wd3).
- The register file commits on the falling edge of clk, so a result held in this stage is written mid-cycle and is readable by decode in the second half of the same cycle.
- Also keeps a retired-instruction counter for the performance/debug path.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
CNT_W, 32, width of the retired-instruction counter instret.

Ports:
clk  input  1  system clock; pipeline registers update on the rising edge.
reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
stall  input  1  hold the W-stage register contents.
flush  input  1  squash the W-stage contents (insert a bubble).
valid_m  input  1  MEM-stage slot holds a real instruction.
regwrite_m  input  1  instruction writes rd.
rd_m  input  5  destination register index.
resultsrc_m  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 treated as ALU.
funct3_m  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
aluresult_m  input  XLEN  ALU result / load address.
readdata_m  input  XLEN  raw aligned 32-bit word from data memory.
pcplus4_m  input  XLEN  PC+4 of the instruction.
we3  output  1  register-file write enable.
a3  output  5  register-file write index.
wd3  output  XLEN  register-file write data.
valid_w  output  1  W slot holds a real instruction.
instret  output  CNT_W  count of instructions retired from W.

Behaviour:
- Clocking: all state updates on the rising edge of clk. Priority is reset > flush > stall > load.
- reset=1: all W registers clear to 0 (valid, regwrite, rd, resultsrc, funct3, data fields) and instret clears to 0. In the following cycle we3=0, a3=0, wd3=0, valid_w=0.
- flush=1 (reset=0): valid_w and regwrite_w clear to 0; other fields are don't-care. flush overrides stall.
- stall=1 (flush=0): all W registers hold. we3 remains asserted if it already was. The regfile then rewrites the same value each cycle, which is idempotent and allowed.
- Otherwise: all *_m inputs are captured. Latency is 1 cycle from M inputs to we3/a3/wd3.
- we3 = valid_w & regwrite_w & (rd_w != 0). Writes to x0 are never issued.
- a3 = rd_w, a combinational function of the registered fields.
- wd3 select, combinational on registered fields:
  - resultsrc 00 or 11: aluresult_w.
  - resultsrc 10: pcplus4_w.
  - resultsrc 01: load extraction (below).
- Load extraction uses offset = aluresult_w[1:0]:
  - LB/LBU: byte = readdata_w[8*offset+7 : 8*offset], sign- or zero-extended to 32 bits.
  - LH/LHU: half = readdata_w[16*offset[1]+15 : 16*offset[1]]; offset[0] is ignored (misaligned halves are not trapped here).
  - LW: the full word; offset is ignored.
  - Any other funct3: the full word.
- instret increments by 1 on a rising edge where reset=0, valid_w=1 and stall=0, i.e. when an instruction leaves W.
  - It counts every valid instruction regardless of regwrite.
  - A flush that arrives while valid_w=1 and stall=0 still counts the departing instruction.
  - It wraps modulo 2^CNT_W.
- Reset mid-operation: a pending writeback is dropped. we3 is low from the cycle after the reset edge.
- No combinational path from any *_m input to any output.

Test Plan:
- Reset, then capture valid_m=1, regwrite_m=1, rd_m=5, resultsrc_m=00, aluresult_m=0x0000_1234 -> next cycle we3=1, a3=5, wd3=0x1234, valid_w=1; instret=1 one cycle later.
- Load readdata_m=0x80FF_7F01 with aluresult_m low bits 01, LB -> wd3=0x0000_007F. With low bits 11, LB -> 0xFFFF_FF80. LBU at 11 -> 0x80. LH at 10 -> 0xFFFF_80FF. LHU at 00 -> 0x7F01.
- rd_m=0, regwrite_m=1, valid_m=1 -> we3=0 and instret still increments. resultsrc_m=10, pcplus4_m=0x104, rd_m=1 -> wd3=0x104, we3=1.
- Capture a valid write, then hold stall=1 for 3 cycles -> we3/a3/wd3 stable for 4 cycles and instret increments once, only after stall drops.
- Assert stall=1 and flush=1 together with a valid W -> next cycle valid_w=0, we3=0. Then reset=1 mid-stream -> instret=0 and all outputs 0.
- With CNT_W=4, retire 17 back-to-back instructions -> instret wraps to 1.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result select, load extraction,
// and a retired-instruction counter. Drives the register-file write port.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_m,
  input  logic             regwrite_m,
  input  logic [4:0]       rd_m,
  input  logic [1:0]       resultsrc_m,
  input  logic [2:0]       funct3_m,
  input  logic [XLEN-1:0]  aluresult_m,
  input  logic [XLEN-1:0]  readdata_m,
  input  logic [XLEN-1:0]  pcplus4_m,
  output logic             we3,
  output logic [4:0]       a3,
  output logic [XLEN-1:0]  wd3,
  output logic             valid_w,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned RegW = 5;

  logic             valid_q,     valid_d;
  logic             regwrite_q,  regwrite_d;
  logic [RegW-1:0]  rd_q,        rd_d;
  logic [1:0]       resultsrc_q, resultsrc_d;
  logic [2:0]       funct3_q,    funct3_d;
  logic [XLEN-1:0]  aluresult_q, aluresult_d;
  logic [XLEN-1:0]  readdata_q,  readdata_d;
  logic [XLEN-1:0]  pcplus4_q,   pcplus4_d;
  logic [CNT_W-1:0] instret_q,   instret_d;

  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [XLEN-1:0]  load_data;

  // Next-state: flush > stall > capture; instret counts departures from W.
  always_comb begin
    valid_d     = valid_q;
    regwrite_d  = regwrite_q;
    rd_d        = rd_q;
    resultsrc_d = resultsrc_q;
    funct3_d    = funct3_q;
    aluresult_d = aluresult_q;
    readdata_d  = readdata_q;
    pcplus4_d   = pcplus4_q;
    instret_d   = instret_q;

    if (flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!stall) begin
      valid_d     = valid_m;
      regwrite_d  = regwrite_m;
      rd_d        = rd_m;
      resultsrc_d = resultsrc_m;
      funct3_d    = funct3_m;
      aluresult_d = aluresult_m;
      readdata_d  = readdata_m;
      pcplus4_d   = pcplus4_m;
    end

    // A flushed-but-unstalled valid instruction still leaves W and is counted.
    if (valid_q && !stall) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // W-stage register file with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
      resultsrc_q <= '0;
      funct3_q    <= '0;
      aluresult_q <= '0;
      readdata_q  <= '0;
      pcplus4_q   <= '0;
      instret_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      rd_q        <= rd_d;
      resultsrc_q <= resultsrc_d;
      funct3_q    <= funct3_d;
      aluresult_q <= aluresult_d;
      readdata_q  <= readdata_d;
      pcplus4_q   <= pcplus4_d;
      instret_q   <= instret_d;
    end
  end

  // Byte/half lane pick from the aligned word; half ignores offset[0].
  always_comb begin
    load_byte = readdata_q[7:0];
    load_half = readdata_q[15:0];
    case (aluresult_q[1:0])
      2'b00:   load_byte = readdata_q[7:0];
      2'b01:   load_byte = readdata_q[15:8];
      2'b10:   load_byte = readdata_q[23:16];
      default: load_byte = readdata_q[31:24];
    endcase
    if (aluresult_q[1]) begin
      load_half = readdata_q[31:16];
    end
  end

  // Sign/zero extension by load type; unknown encodings return the word.
  always_comb begin
    load_data = readdata_q;
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_data = readdata_q;
    endcase
  end

  // Result select and write-port drive; x0 writes are suppressed.
  always_comb begin
    wd3 = aluresult_q;
    case (resultsrc_q)
      2'b01:   wd3 = load_data;
      2'b10:   wd3 = pcplus4_q;
      default: wd3 = aluresult_q;
    endcase
    we3 = valid_q & regwrite_q & (rd_q != '0);
    a3  = rd_q;
  end

  assign valid_w = valid_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/PC+4/load results, x0, stall,
// flush, mid-stream reset and counter wrap (on a CNT_W=4 twin instance).
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_m, regwrite_m;
  logic [4:0]  rd_m;
  logic [1:0]  resultsrc_m;
  logic [2:0]  funct3_m;
  logic [31:0] aluresult_m, readdata_m, pcplus4_m;

  logic        we3, valid_w;
  logic [4:0]  a3;
  logic [31:0] wd3, instret;

  logic        we3_s, valid_w_s;
  logic [4:0]  a3_s;
  logic [31:0] wd3_s;
  logic [3:0]  instret_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_m(valid_m), .regwrite_m(regwrite_m), .rd_m(rd_m),
    .resultsrc_m(resultsrc_m), .funct3_m(funct3_m),
    .aluresult_m(aluresult_m), .readdata_m(readdata_m), .pcplus4_m(pcplus4_m),
    .we3(we3), .a3(a3), .wd3(wd3), .valid_w(valid_w), .instret(instret)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_m(valid_m), .regwrite_m(regwrite_m), .rd_m(rd_m),
    .resultsrc_m(resultsrc_m), .funct3_m(funct3_m),
    .aluresult_m(aluresult_m), .readdata_m(readdata_m), .pcplus4_m(pcplus4_m),
    .we3(we3_s), .a3(a3_s), .wd3(wd3_s), .valid_w(valid_w_s), .instret(instret_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; valid_m = 0; regwrite_m = 0; rd_m = 0;
    resultsrc_m = 0; funct3_m = 0; aluresult_m = 0; readdata_m = 0; pcplus4_m = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got=%b exp=0", we3); end
    checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL reset_a3 got=%0d exp=0", a3); end
    checks++; if (wd3 !== 32'h0) begin errors++; $display("FAIL reset_wd3 got=%h exp=0", wd3); end
    checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_w); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
  endtask

  task automatic test_alu();
    do_reset();
    valid_m = 1; regwrite_m = 1; rd_m = 5; resultsrc_m = 2'b00; aluresult_m = 32'h0000_1234;
    tick();
    valid_m = 0; rd_m = 0; aluresult_m = 0;
    checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL alu_we3 got=%b exp=1", we3); end
    checks++; if (a3 !== 5'd5) begin errors++; $display("FAIL alu_a3 got=%0d exp=5", a3); end
    checks++; if (wd3 !== 32'h1234) begin errors++; $display("FAIL alu_wd3 got=%h exp=1234", wd3); end
    checks++; if (valid_w !== 1'b1) begin errors++; $display("FAIL alu_valid got=%b exp=1", valid_w); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL alu_instret0 got=%0d exp=0", instret); end
    tick();
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL alu_instret1 got=%0d exp=1", instret); end
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL alu_bubble_we3 got=%b exp=0", we3); end
  endtask

  task automatic test_load();
    logic [2:0]  f3  [9] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b100, 3'b101, 3'b011};
    logic [1:0]  off [9] = '{2'b01,  2'b11,  2'b11,  2'b10,  2'b00,  2'b11,  2'b10,  2'b11,  2'b01};
    logic [31:0] exp [9] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                             32'h0000_7F01, 32'h80FF_7F01, 32'h0000_00FF, 32'h0000_80FF,
                             32'h80FF_7F01};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      valid_m = 1; regwrite_m = 1; rd_m = 7; resultsrc_m = 2'b01;
      funct3_m = f3[i]; aluresult_m = {30'h0000_0400, off[i]}; readdata_m = 32'h80FF_7F01;
      tick();
      checks++;
      if (wd3 !== exp[i]) begin
        errors++;
        $display("FAIL load_%0d f3=%b off=%0d got=%h exp=%h", i, f3[i], off[i], wd3, exp[i]);
      end
    end
  endtask

  task automatic test_x0_pc();
    do_reset();
    valid_m = 1; regwrite_m = 1; rd_m = 0; resultsrc_m = 2'b00; aluresult_m = 32'hDEAD;
    tick();
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL x0_we3 got=%b exp=0", we3); end
    checks++; if (valid_w !== 1'b1) begin errors++; $display("FAIL x0_valid got=%b exp=1", valid_w); end
    rd_m = 1; resultsrc_m = 2'b10; pcplus4_m = 32'h104;
    tick();
    checks++; if (wd3 !== 32'h104) begin errors++; $display("FAIL pc4_wd3 got=%h exp=104", wd3); end
    checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL pc4_we3 got=%b exp=1", we3); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL x0_instret got=%0d exp=1", instret); end
    valid_m = 0;
    tick();
    checks++; if (instret !== 32'd2) begin errors++; $display("FAIL pc4_instret got=%0d exp=2", instret); end
  endtask

  task automatic test_stall();
    do_reset();
    valid_m = 1; regwrite_m = 1; rd_m = 3; resultsrc_m = 2'b00; aluresult_m = 32'hABCD;
    tick();
    rd_m = 9; aluresult_m = 32'h5555;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (we3 !== 1'b1 || a3 !== 5'd3 || wd3 !== 32'hABCD || instret !== 32'd0) begin
        errors++;
        $display("FAIL stall_hold_%0d got we3=%b a3=%0d wd3=%h instret=%0d exp 1/3/abcd/0",
                 c, we3, a3, wd3, instret);
      end
      stall = 1;
      if (c < 3) tick();
    end
    stall = 0; valid_m = 0;
    tick();
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL stall_instret got=%0d exp=1", instret); end
    checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL stall_release_valid got=%b exp=0", valid_w); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    valid_m = 1; regwrite_m = 1; rd_m = 4; aluresult_m = 32'h77;
    tick();
    stall = 1; flush = 1;
    tick();
    checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL flushstall_valid got=%b exp=0", valid_w); end
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL flushstall_we3 got=%b exp=0", we3); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL flushstall_instret got=%0d exp=0", instret); end
    stall = 0; flush = 0;
    tick();
    flush = 1;
    tick();
    checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", valid_w); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL flush_instret got=%0d exp=1", instret); end
    flush = 0;
    tick();
    tick();
    checks++; if (instret !== 32'd2 || we3 !== 1'b1) begin
      errors++; $display("FAIL prereset got instret=%0d we3=%b exp 2/1", instret, we3);
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (instret !== 32'd0 || we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'h0 || valid_w !== 1'b0) begin
      errors++;
      $display("FAIL midreset got instret=%0d we3=%b a3=%0d wd3=%h valid=%b exp all 0",
               instret, we3, a3, wd3, valid_w);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      valid_m = 1; regwrite_m = 1; rd_m = 5'(i); resultsrc_m = 2'b00; aluresult_m = 32'(i * 3);
      tick();
      checks++;
      if (wd3 !== 32'(i * 3) || a3 !== 5'(i)) begin
        errors++; $display("FAIL b2b_data_%0d got a3=%0d wd3=%h exp %0d/%h", i, a3, wd3, i, i * 3);
      end
    end
    checks++; if (instret_s !== 4'd0) begin errors++; $display("FAIL b2b_small16 got=%0d exp=0", instret_s); end
    valid_m = 0;
    tick();
    checks++; if (instret_s !== 4'd1) begin errors++; $display("FAIL wrap_small got=%0d exp=1", instret_s); end
    checks++; if (instret !== 32'd17) begin errors++; $display("FAIL wrap_big got=%0d exp=17", instret); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_alu();
    test_load();
    test_x0_pc();
    test_stall();
    test_flush_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
